regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Shares the single write port of the rv32i 32x32 register file between NREQ writeback requesters (ALU, load unit, CSR unit, …).
- Round-robin arbitration with a valid/ready handshake per requester.
- The winner is registered into an output stage that drives the register file write-enable, address and data directly.
- Sits between the execute/memory writeback sources and the register file.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
XLEN, 32, data width
AW, 5, register address width

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
hold  input  1  pipeline freeze; no grants while high
req_valid  input  NREQ  per-requester write request
req_ready  output  NREQ  per-requester accept (one-hot or zero)
req_rd  input  NREQ*AW  flattened destination addresses, requester i at [i*AW +: AW]
req_data  input  NREQ*XLEN  flattened write data, requester i at [i*XLEN +: XLEN]
rf_en  output  1  register file write enable
rf_rd_addr  output  AW  register file write address
rf_data  output  XLEN  register file write data
grant_id  output  3  index of requester that produced the current rf_* beat

Behaviour:
- Reset (rst==0 at posedge): rf_en=0, rf_rd_addr=0, rf_data=0, grant_id=0, rr_ptr=0. req_ready is combinational and is 0 while rst==0.
- Handshake:
  - A transfer occurs on a cycle where req_valid[i] && req_ready[i].
  - req_ready is combinational from req_valid, rr_ptr, hold and rst.
  - At most one bit of req_ready is set per cycle.
  - Requesters hold valid/rd/data stable until accepted.
- Arbitration:
  - Search starts at rr_ptr and wraps modulo NREQ.
  - The first valid requester wins.
  - On a transfer, rr_ptr <= (winner+1) mod NREQ. Otherwise rr_ptr is unchanged.
- Latency: a transfer in cycle N gives rf_en=1 with that rd/data in cycle N+1. The register file write commits at the end of cycle N+1. Throughput is one write per cycle.
- Output stage: loaded every cycle.
  - With no transfer: rf_en<=0; rf_rd_addr, rf_data and grant_id hold their previous values.
- x0: a request with rd==0 is accepted and consumes its round-robin turn. The stage loads rf_rd_addr=0 and rf_data with the data but rf_en<=0. The write is silently dropped.
- hold=1: req_ready=0 for all requesters and rf_en<=0 next cycle. A beat already in the output stage still writes in the cycle hold rises, since it was registered earlier.
- NREQ==1: the pointer stays 0; req_ready = req_valid & ~hold.
- Reset mid-operation: the beat in the output stage is discarded (rf_en forced 0). Pending requests are not accepted until rst returns high.
- Simultaneous requests with the same rd from different requesters: both are accepted on successive cycles in round-robin order. The later write wins in the register file; no merging.

Optional Feature:
Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - Adds inputs rs1_addr, rs2_addr (AW each) and outputs byp_a_hit, byp_b_hit (1 each) and byp_data (XLEN).
  - byp_a_hit = rf_en && rf_rd_addr==rs1_addr && rs1_addr!=0; byp_b_hit is the same against rs2_addr.
  - byp_data = rf_data. All combinational.
  - Lets the decode stage forward a value being written this cycle.
- Undefined: these ports do not exist and no comparison logic is generated.

Decomposition:
- Shared package rv32i_pkg: XLEN, AW, REG_ZERO (5'd0), and a typedef wb_req_t {rd[AW], data[XLEN]}.
- One sub-module, rr_arbiter_onehot (NREQ parameter):
  - Inputs: req, ptr, en.
  - Outputs: one-hot gnt and binary gnt_idx.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
- Reset: rst=0 for 2 cycles with req_valid=3'b111 -> req_ready=0, rf_en=0 throughout. After release, first grant goes to requester 0.
- Round-robin, all valid: requesters 0/1/2 with rd=1/2/3 and data=0xA/0xB/0xC held valid.
  - Grants 0,1,2,0 on consecutive cycles.
  - rf_en=1 from cycle after first grant with (1,0xA),(2,0xB),(3,0xC) in order.
- x0 drop: requester 1 alone, rd=0, data=0xDEADBEEF -> req_ready[1]=1 for one cycle, next cycle rf_en=0. Next grant search starts at requester 2.
- Hold: all valid, hold=1 for 3 cycles mid-stream -> one in-flight beat writes, then rf_en=0 for the remaining hold cycles. After hold drops, arbitration resumes from the saved rr_ptr.
- Same-rd collision: requesters 0 and 2 both rd=5, data 0x11 and 0x22, rr_ptr=0 -> rf writes 0x11 then 0x22. A register file readback of x5 returns 0x22.
- Bypass (REGFILE_WB_BYPASS_EN): rs1_addr=7 while rf_en=1, rf_rd_addr=7, rf_data=0x1234 -> byp_a_hit=1, byp_data=0x1234. With rs1_addr=0 the same beat gives byp_a_hit=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: definitions shared by the rv32i register-file writeback logic.
//   XLEN     : architectural data width
//   AW       : register address width (32 registers)
//   REG_ZERO : address of the hard-wired zero register x0
//   wb_req_t : one writeback request (destination register + data)
package rv32i_pkg;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   localparam logic [AW-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// rr_arbiter_onehot: combinational round-robin arbiter.
// The search starts at ptr and wraps modulo NREQ; the first asserted request
// wins. The pointer register is owned by the parent.
//   req     [NREQ-1:0] in  : request vector
//   ptr     [2:0]      in  : requester that has top priority this cycle
//   en                 in  : when low no grant is issued
//   gnt     [NREQ-1:0] out : one-hot (or zero) grant
//   gnt_idx [2:0]      out : binary index of the granted requester
module rr_arbiter_onehot #(
   parameter int NREQ = 3
) (
   input  logic [NREQ-1:0] req,
   input  logic [2:0]      ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [2:0]      gnt_idx
);

   always_comb begin
      int  idx;
      logic found;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (en && !found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = 3'(idx);
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single write port of the rv32i register file
// between NREQ writeback requesters using round-robin arbitration with a
// valid/ready handshake. The accepted request is registered into an output
// stage that drives the register file write port directly (one cycle latency,
// one write per cycle).
//
// Ports:
//   clk, rst                  : clock, synchronous active-low reset
//   hold                      : pipeline freeze, no grants while high
//   req_valid/req_ready [NREQ]: per-requester handshake (ready one-hot or zero)
//   req_rd   [NREQ*AW]        : destination of requester i at [i*AW +: AW]
//   req_data [NREQ*XLEN]      : data of requester i at [i*XLEN +: XLEN]
//   rf_en, rf_rd_addr, rf_data: register file write port
//   grant_id [3]              : requester that produced the current rf_* beat
//
// Optional feature, macro REGFILE_WB_BYPASS_EN: adds rs1_addr/rs2_addr inputs
// and byp_a_hit/byp_b_hit/byp_data outputs so decode can forward the value
// being written this cycle.
module regfile_wb_arbiter
   import rv32i_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int XLEN = rv32i_pkg::XLEN,
   parameter int AW   = rv32i_pkg::AW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hold,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*AW-1:0]   req_rd,
   input  logic [NREQ*XLEN-1:0] req_data,
   output logic                 rf_en,
   output logic [AW-1:0]        rf_rd_addr,
   output logic [XLEN-1:0]      rf_data,
   output logic [2:0]           grant_id
`ifdef REGFILE_WB_BYPASS_EN
   ,
   input  logic [AW-1:0]        rs1_addr,
   input  logic [AW-1:0]        rs2_addr,
   output logic                 byp_a_hit,
   output logic                 byp_b_hit,
   output logic [XLEN-1:0]      byp_data
`endif
);

   logic [2:0]      rr_ptr_q, rr_ptr_d;
   logic            rf_en_q, rf_en_d;
   logic [AW-1:0]   rf_addr_q, rf_addr_d;
   logic [XLEN-1:0] rf_data_q, rf_data_d;
   logic [2:0]      grant_q, grant_d;

   logic [NREQ-1:0] gnt;
   logic [2:0]      gnt_idx;
   logic            arb_en;
   logic            xfer;
   logic [AW-1:0]   rd_sel;
   logic [XLEN-1:0] data_sel;

   // Ready must drop during reset as well as during hold.
   assign arb_en = rst && !hold;

   rr_arbiter_onehot #(.NREQ(NREQ)) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .en      (arb_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign req_ready = gnt;
   assign xfer      = |gnt;

   always_comb begin
      rd_sel   = '0;
      data_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            rd_sel   = req_rd[i*AW +: AW];
            data_sel = req_data[i*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      grant_d   = grant_q;
      // x0 requests still load address/data but never assert the write enable.
      rf_en_d   = xfer && (rd_sel != AW'(REG_ZERO));
      if (xfer) begin
         rr_ptr_d  = 3'((int'(gnt_idx) + 1) % NREQ);
         rf_addr_d = rd_sel;
         rf_data_d = data_sel;
         grant_d   = gnt_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr_q  <= '0;
         rf_en_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
         grant_q   <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         rf_en_q   <= rf_en_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
         grant_q   <= grant_d;
      end
   end

   assign rf_en      = rf_en_q;
   assign rf_rd_addr = rf_addr_q;
   assign rf_data    = rf_data_q;
   assign grant_id   = grant_q;

`ifdef REGFILE_WB_BYPASS_EN
   assign byp_a_hit = rf_en_q && (rf_addr_q == rs1_addr) && (rs1_addr != AW'(REG_ZERO));
   assign byp_b_hit = rf_en_q && (rf_addr_q == rs2_addr) && (rs2_addr != AW'(REG_ZERO));
   assign byp_data  = rf_data_q;
`else
   // Forwarding disabled: no comparators are built.
`endif

endmodule
